// File: rtl/simon_playback_sequencer.sv
// Timed playback of the Simon pattern store: fetch each entry, show it on the
// LED bus for ON_CYCLES, blank it for OFF_CYCLES, then pulse done.
module simon_playback_sequencer #(
  parameter int WIDTH      = 4,
  parameter int ADDR_W     = 6,
  parameter int TIMER_W    = 24,
  parameter int ON_CYCLES  = 12500000,
  parameter int OFF_CYCLES = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  led_out,
  output logic [ADDR_W-1:0] play_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHOW,
    S_GAP,
    S_FINISH
  } state_t;

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

  state_t              r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [WIDTH-1:0]    r_led;
  logic                r_rd_en;
  logic                r_busy;
  logic                r_done;

  logic [ADDR_W:0]     w_len_m1;
  logic                w_last;
  logic [ADDR_W-1:0]   w_idx_next;

  // Compare at ADDR_W+1 bits so len == 2^ADDR_W plays every address without wrap.
  assign w_len_m1   = r_len - {{ADDR_W{1'b0}}, 1'b1};
  assign w_last     = ({1'b0, r_idx} == w_len_m1);
  assign w_idx_next = r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_led     <= '0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_led   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_len  <= len;
              r_busy <= 1'b1;
              if (len != '0) begin
                r_idx     <= '0;
                r_rd_addr <= '0;
                r_rd_en   <= 1'b1;
                r_state   <= S_FETCH;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_FINISH;
              end
            end
          end
          S_FETCH: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            r_led   <= rd_data;
            r_timer <= ON_LOAD;
            r_state <= S_SHOW;
          end
          S_SHOW: begin
            if (r_timer != '0) begin
              r_timer <= r_timer - 1'b1;
            end else begin
              r_led   <= '0;
              r_timer <= OFF_LOAD;
              r_state <= S_GAP;
            end
          end
          S_GAP: begin
            if (r_timer != '0) begin
              r_timer <= r_timer - 1'b1;
            end else if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_idx     <= w_idx_next;
              r_rd_addr <= w_idx_next;
              r_rd_en   <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
          S_FINISH: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_en    = r_rd_en;
  assign rd_addr  = r_rd_addr;
  assign led_out  = r_led;
  assign play_idx = r_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Directed bench for simon_playback_sequencer: per-cycle expectation tables
// for the timed scenarios, plus hand-written async-reset and full-depth runs.
module tb_simon_playback_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: ADDR_W=6, short timers
  logic       a_start = 1'b0, a_abort = 1'b0;
  logic [6:0] a_len = '0;
  logic       a_rd_en, a_busy, a_done;
  logic [5:0] a_rd_addr, a_idx;
  logic [3:0] a_rd_data = '0, a_led;
  logic [3:0] mem_a [0:63];

  // DUT B: ADDR_W=2 for full-depth playback
  logic       b_start = 1'b0, b_abort = 1'b0;
  logic [2:0] b_len = '0;
  logic       b_rd_en, b_busy, b_done;
  logic [1:0] b_rd_addr, b_idx;
  logic [3:0] b_rd_data = '0, b_led;
  logic [3:0] mem_b [0:3];

  simon_playback_sequencer #(.WIDTH(4), .ADDR_W(6), .TIMER_W(24), .ON_CYCLES(3), .OFF_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .len(a_len),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .led_out(a_led),
    .play_idx(a_idx), .busy(a_busy), .done(a_done));

  simon_playback_sequencer #(.WIDTH(4), .ADDR_W(2), .TIMER_W(24), .ON_CYCLES(3), .OFF_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .len(b_len),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .led_out(b_led),
    .play_idx(b_idx), .busy(b_busy), .done(b_done));

  // One-cycle-latency pattern memories
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
  end

  typedef struct {
    logic       start;
    logic       abort;
    logic [6:0] len;
    logic       rd_en;
    logic [5:0] addr;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [5:0] idx;
    logic       chk_idx;
  } vec_t;

  vec_t tbl [0:24];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string what, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", what, cyc, act, exp);
    end
  endtask

  // Scenario 1 timeline: entry k fetched at 1+7k, shown 3+7k..5+7k, done at 22.
  function automatic vec_t normal_vec(input int c);
    vec_t v;
    v.start   = (c == 0);
    v.abort   = 1'b0;
    v.len     = 7'd3;
    v.rd_en   = (c == 1) || (c == 8) || (c == 15);
    v.addr    = (c >= 15) ? 6'd2 : (c >= 8) ? 6'd1 : 6'd0;
    v.idx     = v.addr;
    v.led     = (c >= 3 && c <= 5)   ? 4'h1 :
                (c >= 10 && c <= 12) ? 4'h2 :
                (c >= 17 && c <= 19) ? 4'h4 : 4'h0;
    v.busy    = (c >= 1 && c <= 22);
    v.done    = (c == 22);
    v.chk_idx = 1'b1;
    return v;
  endfunction

  task automatic fill_normal();
    for (int c = 0; c < 25; c++) tbl[c] = normal_vec(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_len = '0;
    b_start = 1'b0; b_abort = 1'b0; b_len = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Cycle k is checked at its negedge, then its inputs are driven for the next posedge.
  task automatic run_tbl(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({name, ".rd_en"}, k, 32'(a_rd_en), 32'(tbl[k].rd_en));
      check({name, ".rd_addr"}, k, 32'(a_rd_addr), 32'(tbl[k].addr));
      check({name, ".led"}, k, 32'(a_led), 32'(tbl[k].led));
      check({name, ".busy"}, k, 32'(a_busy), 32'(tbl[k].busy));
      check({name, ".done"}, k, 32'(a_done), 32'(tbl[k].done));
      if (tbl[k].chk_idx) check({name, ".idx"}, k, 32'(a_idx), 32'(tbl[k].idx));
      a_start = tbl[k].start;
      a_abort = tbl[k].abort;
      a_len   = tbl[k].len;
    end
    a_start = 1'b0;
    a_abort = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_a[i] = 4'h8;
    mem_a[0] = 4'h1; mem_a[1] = 4'h2; mem_a[2] = 4'h4;
    mem_b[0] = 4'h3; mem_b[1] = 4'h5; mem_b[2] = 4'h9; mem_b[3] = 4'h6;

    // Reset values while rst is held low
    #2;
    check("rst.led", 0, 32'(a_led), 32'h0);
    check("rst.busy", 0, 32'(a_busy), 32'h0);
    check("rst.done", 0, 32'(a_done), 32'h0);
    check("rst.rd_en", 0, 32'(a_rd_en), 32'h0);

    // 1. Normal playback
    do_reset();
    fill_normal();
    run_tbl("normal", 25);

    // 2. Empty playback
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tbl[c] = normal_vec(30);
      tbl[c].start = 1'b0;
      tbl[c].len   = 7'd0;
      tbl[c].addr  = 6'd0;
      tbl[c].idx   = 6'd0;
    end
    tbl[0].start = 1'b1;
    tbl[1].busy  = 1'b1;
    tbl[1].done  = 1'b1;
    run_tbl("empty", 4);

    // 3. Abort during the second SHOW
    do_reset();
    fill_normal();
    tbl[11].abort = 1'b1;
    for (int c = 12; c < 25; c++) begin
      tbl[c].rd_en   = 1'b0;
      tbl[c].addr    = 6'd1;
      tbl[c].led     = 4'h0;
      tbl[c].busy    = 1'b0;
      tbl[c].done    = 1'b0;
      tbl[c].chk_idx = 1'b0;
    end
    run_tbl("abort", 25);

    // 4. start and len change while busy are ignored
    do_reset();
    fill_normal();
    tbl[9].start = 1'b1;
    for (int c = 9; c < 25; c++) tbl[c].len = 7'd1;
    run_tbl("busy_in", 25);

    // 5. Async reset mid-SHOW, then a fresh run
    do_reset();
    fill_normal();
    run_tbl("pre_rst", 5);
    #1 rst = 1'b0;
    #1;
    check("async.led", 4, 32'(a_led), 32'h0);
    check("async.busy", 4, 32'(a_busy), 32'h0);
    check("async.done", 4, 32'(a_done), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_tbl("post_rst", 25);

    // 6. Full depth on ADDR_W=2: reads 0..3 at 1,8,15,22, done at 29, nothing after
    do_reset();
    @(negedge clk);
    b_start = 1'b1;
    b_len   = 3'd4;
    begin
      int reads, dones, done_cyc;
      reads = 0; dones = 0; done_cyc = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        b_start = 1'b0;
        if (b_rd_en) begin
          check("full.rd_addr", c, 32'(b_rd_addr), 32'(reads));
          check("full.rd_cycle", c, 32'(c), 32'(1 + 7 * reads));
          reads++;
        end
        if (b_led != 4'h0) check("full.led", c, 32'(b_led), 32'(mem_b[b_idx]));
        if (b_done) begin
          dones++;
          done_cyc = c;
        end
      end
      check("full.reads", 40, 32'(reads), 32'd4);
      check("full.dones", 40, 32'(dones), 32'd1);
      check("full.done_cycle", 40, 32'(done_cyc), 32'd29);
      check("full.busy_end", 40, 32'(b_busy), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
